// File: rtl/pipe_field.sv
// Scrolling obstacle field for the flappy-bird game: column shift register with
// LFSR-placed pipe gaps, one-cycle-delayed collision/score check, and a renderer read port.
module pipe_field #(
  parameter int unsigned NCOL      = 40,
  parameter int unsigned HW        = 7,
  parameter int unsigned FIELD_H   = 80,
  parameter int unsigned GAP       = 20,
  parameter int unsigned SPACING   = 8,
  parameter int unsigned BIRD_COL  = 1,
  parameter int unsigned SCW       = 8,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    start,
  input  logic                    tick,
  input  logic [HW-1:0]           bird_y,
  input  logic [$clog2(NCOL)-1:0] rd_col,
  output logic                    rd_pipe,
  output logic [HW-1:0]           rd_gap_lo,
  output logic                    running,
  output logic                    collide,
  output logic [SCW-1:0]          score
);
  localparam int unsigned SW   = $clog2(SPACING);
  localparam int unsigned GMOD = FIELD_H - GAP - 1;

  typedef enum logic [1:0] {IDLE, RUN, DEAD} state_t;

  state_t                   state_q, state_d;
  logic [NCOL-1:0]          pipe_q, pipe_d;
  logic [NCOL-1:0][HW-1:0]  gap_q, gap_d;
  logic [SW-1:0]            spc_q, spc_d;
  logic [15:0]              lfsr_q, lfsr_d;
  logic                     check_q, check_d;
  logic [HW-1:0]            bird_q, bird_d;
  logic                     collide_q, collide_d;
  logic [SCW-1:0]           score_q, score_d;

  logic [15:0]              lfsr_next;
  logic [HW-1:0]            new_gap;
  logic                     hit;

  assign lfsr_next = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
  assign new_gap   = HW'(32'(lfsr_q[HW-1:0]) % GMOD + 32'd1);

  // Evaluated on the already-shifted field, so BIRD_COL holds the column the bird just entered.
  always_comb begin
    hit = (bird_q == '0) || (32'(bird_q) >= FIELD_H - 1);
    if (pipe_q[BIRD_COL] &&
        ((32'(bird_q) < 32'(gap_q[BIRD_COL])) ||
         (32'(bird_q) > 32'(gap_q[BIRD_COL]) + GAP - 1)))
      hit = 1'b1;
  end

  always_comb begin
    state_d   = state_q;
    pipe_d    = pipe_q;
    gap_d     = gap_q;
    spc_d     = spc_q;
    lfsr_d    = lfsr_q;
    check_d   = 1'b0;
    bird_d    = bird_q;
    collide_d = collide_q;
    score_d   = score_q;

    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (start) state_d = RUN;
               else if (collide_q) state_d = DEAD;
      DEAD:    if (start) state_d = RUN;
      default: state_d = IDLE;
    endcase

    if (check_q) begin
      if (hit)
        collide_d = 1'b1;
      else if (pipe_q[BIRD_COL] && (score_q != '1))
        score_d = score_q + SCW'(1);
    end

    // start overrides both a pending check result and a same-cycle tick.
    if (start) begin
      pipe_d    = '0;
      gap_d     = '0;
      spc_d     = '0;
      score_d   = '0;
      collide_d = 1'b0;
      check_d   = 1'b0;
    end else if (tick && (state_q == RUN)) begin
      pipe_d = {1'b0, pipe_q[NCOL-1:1]};
      gap_d  = {HW'(0), gap_q[NCOL-1:1]};
      if (spc_q == SW'(SPACING - 1)) begin
        pipe_d[NCOL-1] = 1'b1;
        gap_d[NCOL-1]  = new_gap;
        lfsr_d         = lfsr_next;
        spc_d          = '0;
      end else begin
        spc_d = spc_q + SW'(1);
      end
      bird_d  = bird_y;
      check_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= IDLE;
      pipe_q    <= '0;
      gap_q     <= '0;
      spc_q     <= '0;
      lfsr_q    <= LFSR_SEED;
      check_q   <= 1'b0;
      bird_q    <= '0;
      collide_q <= 1'b0;
      score_q   <= '0;
    end else begin
      state_q   <= state_d;
      pipe_q    <= pipe_d;
      gap_q     <= gap_d;
      spc_q     <= spc_d;
      lfsr_q    <= lfsr_d;
      check_q   <= check_d;
      bird_q    <= bird_d;
      collide_q <= collide_d;
      score_q   <= score_d;
    end
  end

  always_comb begin
    rd_pipe   = 1'b0;
    rd_gap_lo = '0;
    if ((32'(rd_col) < NCOL) && pipe_q[rd_col]) begin
      rd_pipe   = 1'b1;
      rd_gap_lo = gap_q[rd_col];
    end
  end

  assign running = (state_q == RUN);
  assign collide = collide_q;
  assign score   = score_q;

endmodule

// File: tb/tb_pipe_field.sv
// Bench for pipe_field: tick-level game model (column array, LFSR, score rules) vs. two DUTs
// sharing stimulus, one default and one with a 2-bit score.
module tb_pipe_field;
  localparam int NCOL = 40, HW = 7, FH = 80, GAP = 20, SP = 8, BC = 1;

  logic clk = 1'b0, resetn = 1'b0, start = 1'b0, tick = 1'b0;
  logic [HW-1:0] bird_y = '0;
  logic [5:0]    rd_col = '0;
  logic          rd_pipe, rd_pipe2, running, running2, collide, collide2;
  logic [HW-1:0] rd_gap_lo, rd_gap_lo2;
  logic [7:0]    score;
  logic [1:0]    score2;

  int tests = 0, fails = 0, cyc = 0;

  pipe_field dut (
    .clk(clk), .resetn(resetn), .start(start), .tick(tick), .bird_y(bird_y), .rd_col(rd_col),
    .rd_pipe(rd_pipe), .rd_gap_lo(rd_gap_lo), .running(running), .collide(collide), .score(score));

  pipe_field #(.SCW(2)) dut2 (
    .clk(clk), .resetn(resetn), .start(start), .tick(tick), .bird_y(bird_y), .rd_col(rd_col),
    .rd_pipe(rd_pipe2), .rd_gap_lo(rd_gap_lo2), .running(running2), .collide(collide2), .score(score2));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, got no finish, expected finish");
    $fatal(1, "timeout");
  end

  // ---------------- reference model ----------------
  bit          m_pipe [NCOL];
  int          m_gap  [NCOL];
  int          m_spc, m_score, m_ce;
  bit          m_coll, m_run;
  logic [15:0] m_lfsr;

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return (l >> 1) ^ (l[0] ? 16'hB400 : 16'h0000);
  endfunction

  function automatic void m_clear();
    for (int i = 0; i < NCOL; i++) begin m_pipe[i] = 1'b0; m_gap[i] = 0; end
    m_spc = 0; m_score = 0; m_coll = 1'b0; m_ce = 0;
  endfunction

  function automatic void m_reset();
    m_clear(); m_run = 1'b0; m_lfsr = 16'hACE1;
  endfunction

  function automatic void m_start();
    m_clear(); m_run = 1'b1;
  endfunction

  // A collision seen on the tick at edge ce stops the game; ticks up to edge ce+2 still land.
  function automatic void m_tick(input int e, input int by);
    bit h;
    logic [HW-1:0] lo;
    if (!m_run || (m_coll && e > m_ce + 2)) return;
    for (int i = 0; i < NCOL - 1; i++) begin m_pipe[i] = m_pipe[i+1]; m_gap[i] = m_gap[i+1]; end
    if (m_spc == SP - 1) begin
      lo = m_lfsr[HW-1:0];
      m_pipe[NCOL-1] = 1'b1;
      m_gap[NCOL-1]  = 1 + int'(lo) % (FH - GAP - 1);
      m_lfsr = lfsr_step(m_lfsr);
      m_spc  = 0;
    end else begin
      m_pipe[NCOL-1] = 1'b0; m_gap[NCOL-1] = 0; m_spc++;
    end
    h = (by == 0) || (by >= FH - 1) ||
        (m_pipe[BC] && ((by < m_gap[BC]) || (by > m_gap[BC] + GAP - 1)));
    if (h) begin
      if (!m_coll) begin m_coll = 1'b1; m_ce = e; end
    end else if (m_pipe[BC] && m_score < 255) m_score++;
  endfunction

  function automatic bit exp_running();
    return m_run && !(m_coll && cyc >= m_ce + 2);
  endfunction

  function automatic bit exp_collide();
    return m_coll && cyc >= m_ce + 1;
  endfunction

  function automatic int safe_y();
    if (m_pipe[BC+1]) return m_gap[BC+1] + int'($urandom_range(0, GAP - 1));
    return int'($urandom_range(1, FH - 2));
  endfunction

  // ---------------- stimulus ----------------
  task automatic drive(input bit st, input bit tk, input int by, input bit rn);
    start = st; tick = tk; bird_y = HW'(by); resetn = rn;
    @(negedge clk);
    if (!rn) m_reset();
    else if (st) m_start();
    else if (tk) m_tick(cyc, by);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(1'b0, 1'b0, int'(bird_y), 1'b1);
  endtask

  task automatic tk(input int by);
    drive(1'b0, 1'b1, by, 1'b1);
    idle(2);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    bit ep; int eg;
    drive(1'b0, 1'b0, 40, 1'b0);
    drive(1'b0, 1'b0, 40, 1'b0);
    tests++;
    if (running !== 1'b0 || collide !== 1'b0 || score !== 8'd0 || score2 !== 2'd0) begin
      fails++;
      $display("FAIL reset_outputs: running=%0b collide=%0b score=%0d score2=%0d, expected 0 0 0 0",
               running, collide, score, score2);
    end
    idle(1);
    for (int c = 0; c < 64; c++) begin
      @(negedge clk); rd_col = 6'(c); #1;
      ep = 1'b0; if (c < NCOL) ep = m_pipe[c];
      eg = 0;    if (ep) eg = m_gap[c];
      tests++;
      if (rd_pipe !== ep || rd_gap_lo !== HW'(eg) || rd_pipe2 !== ep) begin
        fails++;
        $display("FAIL reset_field[%0d]: pipe=%0b gap=%0d, expected pipe=%0b gap=%0d", c, rd_pipe, rd_gap_lo, ep, eg);
      end
    end
  endtask

  task automatic test_first_pipe();
    bit ep; int eg;
    drive(1'b1, 1'b0, 40, 1'b1);
    idle(1);
    tests++;
    if (running !== 1'b1) begin
      fails++; $display("FAIL start_running: running=%0b, expected 1", running);
    end
    for (int t = 0; t < 7; t++) tk(40);
    for (int c = 0; c < NCOL; c++) begin
      @(negedge clk); rd_col = 6'(c); #1;
      ep = m_pipe[c]; eg = ep ? m_gap[c] : 0;
      tests++;
      if (rd_pipe !== 1'b0 || rd_pipe !== ep || rd_gap_lo !== HW'(eg)) begin
        fails++;
        $display("FAIL seven_ticks_empty[%0d]: pipe=%0b gap=%0d, expected pipe=0 gap=0", c, rd_pipe, rd_gap_lo);
      end
    end
    tk(40);
    rd_col = 6'd39; #1;
    tests++;
    if (rd_pipe !== 1'b1 || rd_gap_lo !== 7'd39 || m_gap[39] != 39) begin
      fails++;
      $display("FAIL first_pipe: pipe=%0b gap=%0d (model gap %0d), expected pipe=1 gap=39", rd_pipe, rd_gap_lo, m_gap[39]);
    end
  endtask

  task automatic test_score();
    for (int t = 8; t < 46; t++) tk(49);
    tests++;
    if (score !== 8'd1 || collide !== 1'b0 || running !== 1'b1) begin
      fails++;
      $display("FAIL first_clear: score=%0d collide=%0b running=%0b, expected 1 0 1", score, collide, running);
    end
    for (int t = 0; t < 8; t++) tk(49);
    tests++;
    if (score !== 8'(m_score) || collide !== exp_collide() || running !== exp_running()) begin
      fails++;
      $display("FAIL second_pipe: score=%0d collide=%0b running=%0b, expected %0d %0b %0b",
               score, collide, running, m_score, exp_collide(), exp_running());
    end
  endtask

  task automatic test_collide();
    bit ep; int eg;
    drive(1'b0, 1'b0, 10, 1'b0);
    drive(1'b1, 1'b0, 10, 1'b1);
    for (int t = 0; t < 46; t++) tk(10);
    tests++;
    if (collide !== 1'b1 || running !== 1'b0 || score !== 8'd0 || collide2 !== 1'b1) begin
      fails++;
      $display("FAIL pipe_hit: collide=%0b running=%0b score=%0d, expected 1 0 0", collide, running, score);
    end
    for (int t = 0; t < 5; t++) tk(40);
    for (int c = 0; c < NCOL; c++) begin
      @(negedge clk); rd_col = 6'(c); #1;
      ep = m_pipe[c]; eg = ep ? m_gap[c] : 0;
      tests++;
      if (rd_pipe !== ep || rd_gap_lo !== HW'(eg)) begin
        fails++;
        $display("FAIL frozen_field[%0d]: pipe=%0b gap=%0d, expected pipe=%0b gap=%0d", c, rd_pipe, rd_gap_lo, ep, eg);
      end
    end
  endtask

  task automatic test_floor_ceiling();
    int ys [5] = '{0, 79, 127, 78, 1};
    bit ec [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 1'b0, 40, 1'b1);
      idle(1);
      tk(ys[k]);
      tests++;
      if (collide !== ec[k] || running !== !ec[k] || collide !== exp_collide() || score !== 8'd0) begin
        fails++;
        $display("FAIL bounds_y%0d: collide=%0b running=%0b score=%0d, expected %0b %0b 0",
                 ys[k], collide, running, score, ec[k], !ec[k]);
      end
    end
  endtask

  task automatic test_restart();
    bit ep; int eg;
    tk(0);
    idle(1);
    tests++;
    if (running !== 1'b0 || collide !== 1'b1) begin
      fails++; $display("FAIL enter_dead: running=%0b collide=%0b, expected 0 1", running, collide);
    end
    drive(1'b1, 1'b1, 40, 1'b1);
    idle(1);
    tests++;
    if (running !== 1'b1 || collide !== 1'b0 || score !== 8'd0) begin
      fails++;
      $display("FAIL start_with_tick: running=%0b collide=%0b score=%0d, expected 1 0 0", running, collide, score);
    end
    for (int c = 0; c < NCOL; c++) begin
      @(negedge clk); rd_col = 6'(c); #1;
      ep = m_pipe[c]; eg = ep ? m_gap[c] : 0;
      tests++;
      if (rd_pipe !== 1'b0 || rd_pipe !== ep || rd_gap_lo !== HW'(eg)) begin
        fails++;
        $display("FAIL restart_field[%0d]: pipe=%0b gap=%0d, expected pipe=0 gap=0", c, rd_pipe, rd_gap_lo);
      end
    end
    for (int t = 0; t < 7; t++) tk(40);
    rd_col = 6'd39; #1;
    tests++;
    if (rd_pipe !== 1'b0) begin
      fails++; $display("FAIL restart_seven: pipe=%0b, expected 0", rd_pipe);
    end
    tk(40);
    rd_col = 6'd39; #1;
    tests++;
    if (rd_pipe !== 1'b1 || rd_gap_lo === 7'd39 || rd_gap_lo !== HW'(m_gap[39])) begin
      fails++;
      $display("FAIL restart_pipe: pipe=%0b gap=%0d, expected pipe=1 gap=%0d (not 39)", rd_pipe, rd_gap_lo, m_gap[39]);
    end
  endtask

  task automatic test_back_to_back();
    bit ep; int eg, y, g;
    for (int it = 0; it < 500; it++) begin
      if (!exp_running() || $urandom_range(0, 199) == 0)
        drive(1'b1, 1'($urandom_range(0, 1)), 40, 1'b1);
      else begin
        y = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 127)) : safe_y();
        drive(1'b0, 1'b1, y, 1'b1);
      end
      g = int'($urandom_range(0, 2));
      if (g > 0) idle(g);
      if (it % 50 == 49) begin
        idle(2);
        tests++;
        if (score !== 8'(m_score) || score2 !== 2'((m_score > 3) ? 3 : m_score) ||
            collide !== exp_collide() || running !== exp_running()) begin
          fails++;
          $display("FAIL random_it%0d: score=%0d score2=%0d collide=%0b running=%0b, expected %0d %0d %0b %0b",
                   it, score, score2, collide, running, m_score, (m_score > 3) ? 3 : m_score,
                   exp_collide(), exp_running());
        end
      end
    end
    for (int c = 0; c < NCOL; c++) begin
      @(negedge clk); rd_col = 6'(c); #1;
      ep = m_pipe[c]; eg = ep ? m_gap[c] : 0;
      tests++;
      if (rd_pipe !== ep || rd_gap_lo !== HW'(eg) || rd_gap_lo2 !== HW'(eg)) begin
        fails++;
        $display("FAIL random_field[%0d]: pipe=%0b gap=%0d, expected pipe=%0b gap=%0d", c, rd_pipe, rd_gap_lo, ep, eg);
      end
    end
  endtask

  task automatic test_saturation();
    bit ep; int eg, n;
    drive(1'b0, 1'b0, 40, 1'b0);
    drive(1'b1, 1'b0, 40, 1'b1);
    n = 0;
    while (m_score < 5 && n < 120) begin tk(safe_y()); n++; end
    tests++;
    if (n >= 120 || score !== 8'd5 || score2 !== 2'd3 || collide !== 1'b0) begin
      fails++;
      $display("FAIL saturate: score=%0d score2=%0d collide=%0b after %0d ticks, expected 5 3 0", score, score2, collide, n);
    end
    drive(1'b0, 1'b1, safe_y(), 1'b1);
    drive(1'b0, 1'b0, 40, 1'b0);
    tests++;
    if (running !== 1'b0 || collide !== 1'b0 || score !== 8'd0 || score2 !== 2'd0 || running2 !== 1'b0) begin
      fails++;
      $display("FAIL midrun_reset: running=%0b collide=%0b score=%0d score2=%0d, expected 0 0 0 0",
               running, collide, score, score2);
    end
    for (int c = 0; c < 64; c++) begin
      @(negedge clk); rd_col = 6'(c); #1;
      ep = 1'b0; if (c < NCOL) ep = m_pipe[c];
      eg = 0;    if (ep) eg = m_gap[c];
      tests++;
      if (rd_pipe !== ep || rd_gap_lo !== HW'(eg)) begin
        fails++;
        $display("FAIL midrun_reset_field[%0d]: pipe=%0b gap=%0d, expected pipe=%0b gap=%0d", c, rd_pipe, rd_gap_lo, ep, eg);
      end
    end
    idle(1);
  endtask

  initial begin
    m_reset();
    test_reset();
    test_first_pipe();
    test_score();
    test_collide();
    test_floor_ceiling();
    test_restart();
    test_back_to_back();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
